fir_decimator: RTL and testbench
================================

# fir_decimator

Decimating accumulator directly downstream of the 4-bit FIR filter stage. It sums every DECIM consecutive qualified filter outputs into one wider result and queues the results in a small FIFO. The FIFO drains to the next consumer over a valid/ready handshake. Overflow of the FIFO is reported through a sticky flag, so sample loss is never silent.

## Interface
- IN_W, 4: width of filter output sample (unsigned).
- DECIM, 4: samples summed per result; power of two, 2..16.
- ACC_W, 6: accumulator/result width; legal range IN_W..IN_W+log2(DECIM).
- DEPTH, 4: FIFO entries; power of two, 2..16.

- clock  in  1  rising-edge clock, single domain.
- reset  in  1  asynchronous, active-low; clears all state.
- in_en  in  1  qualifies in_data this cycle.
- in_data  in  IN_W  filter output sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  ACC_W  FIFO head; 0 when empty.
- fifo_count  out  log2(DEPTH)+1  entries held.
- overflow  out  1  sticky: a completed result was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Phase counter ph, 0..DECIM-1, and accumulator acc, ACC_W bits.
- in_en=1 and ph<DECIM-1: acc <= acc+in_data, ph <= ph+1.
- in_en=1 and ph=DECIM-1 (block complete): result = acc+in_data. Then acc <= 0 and ph <= 0, and the result is pushed.
- in_en=0: acc and ph hold. Gaps in in_en never break a block.
- The sum is zero-extended to ACC_W and wraps modulo 2^ACC_W (see Configuration).
- Pop occurs when out_valid && out_ready. The head advances and fifo_count decrements.
- A push is accepted when fifo_count<DEPTH, or when fifo_count=DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop: fifo_count is unchanged and ordering is preserved.
- Rejected push: the result is discarded, overflow <= 1, and acc/ph still clear.
- overflow: clr_ovf=1 clears it. If a rejected push and clr_ovf occur in the same cycle, set wins and overflow=1.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by fifo_count only.
- out_data is registered head data. If fifo_count=0, out_data=0.

## Timing
- Reset asserted (reset=0), asynchronous: acc=0, ph=0, FIFO empty, out_valid=0, out_data=0, fifo_count=0, overflow=0.
- Reset asserted mid-block discards the partial sum and all queued results.
- Reset deassertion is synchronous to clock. The first edge with reset=1 may accept a sample.
- Latency: the block-completing sample is sampled at edge k. With an empty FIFO, out_valid=1 and out_data=result after edge k.
- A pop at edge j makes the next entry visible after edge j. out_valid stays high back-to-back while entries remain.
- Throughput: at most one result every DECIM cycles. With out_ready held at 1, no overflow occurs.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.

## Configuration
- FIR_DEC_SAT_EN defined: the accumulator add saturates at 2^ACC_W-1 instead of wrapping, and the saturated value is the pushed result.
- FIR_DEC_SAT_EN undefined: modulo-2^ACC_W wrap. No saturation logic is built.
- Defaults (ACC_W=6, DECIM=4, IN_W=4) cannot overflow, so the macro matters only for a reduced ACC_W.

## Test plan
- Reset then basic block: in_en=1, in_data 1,2,3,4 -> after the 4th edge, out_valid=1, out_data=10, fifo_count=1. With out_ready=1 the next edge gives out_valid=0, out_data=0.
- Gapped input: samples 15,15,15,15 with in_en=0 between each -> single result 60, no earlier output.
- Backpressure and overflow: out_ready=0, five blocks of 1,1,1,1 -> fifo_count=4, overflow=1 after the 5th block. Draining yields four results of 4. Then clr_ovf=1 -> overflow=0.
- Full with simultaneous pop: FIFO full, a block completes in the same cycle out_ready=1 -> fifo_count stays 4, overflow stays 0, results come out in order.
- Async reset mid-block: after samples 5,6, drive reset=0 between edges -> outputs go to 0 immediately. After release, samples 1,1,1,1 -> result 4.
- ACC_W=4, samples 8,8,8,8: without FIR_DEC_SAT_EN -> result 0 (32 mod 16). With FIR_DEC_SAT_EN -> result 15.

Source files
------------

// File: rtl/fir_decimator.sv
// fir_decimator: sums every DECIM qualified filter samples into one ACC_W-bit
// result and queues results in a DEPTH-entry FIFO drained over valid/ready.
// A result that finds the FIFO full is dropped and latches the sticky overflow.
// Optional build macro: FIR_DEC_SAT_EN -- accumulator saturates at 2^ACC_W-1
// instead of wrapping modulo 2^ACC_W.
module fir_decimator #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned DECIM = 4,
  parameter int unsigned ACC_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_en,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned PH_W  = $clog2(DECIM);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PH_W-1:0]  ph;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [ACC_W-1:0] head_nxt;
  logic             blk_done, pop, push_ok, push_rej;

`ifdef FIR_DEC_SAT_EN
  // One extra bit catches the carry; any carry means the sum is clamped.
  logic [ACC_W:0] sum_ext;
  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(in_data);
  assign sum     = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
  assign sum = acc + ACC_W'(in_data);
`endif

  assign blk_done  = in_en && (ph == PH_W'(DECIM - 1));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the result if the head leaves this same cycle.
  assign push_ok   = blk_done && ((fifo_count < CNT_W'(DEPTH)) || pop);
  assign push_rej  = blk_done && !push_ok;
  assign rd_nxt    = rd_ptr + 1'b1;

  // Phase/accumulator: gaps in in_en hold state; block completion clears both.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph  <= '0;
      acc <= '0;
    end else if (in_en) begin
      if (blk_done) begin
        ph  <= '0;
        acc <= '0;
      end else begin
        ph  <= ph + 1'b1;
        acc <= sum;
      end
    end
  end

  // FIFO storage; contents are meaningless outside fifo_count, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= sum;
  end

  // Next registered head: the entry behind a popped head, a result landing
  // in an empty (or emptying) FIFO, or zero when nothing is left.
  always_comb begin
    head_nxt = out_data;
    if (pop) begin
      if (fifo_count > CNT_W'(1)) head_nxt = mem[rd_nxt];
      else if (push_ok)           head_nxt = sum;
      else                        head_nxt = '0;
    end else if (!out_valid && push_ok) begin
      head_nxt = sum;
    end
  end

  // Pointers, occupancy, registered head and sticky overflow (set beats clear).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_nxt;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      out_data <= head_nxt;
      if (push_rej)     overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed plus random stimulus against a queue-based
// reference model. Two instances run in lockstep: default widths and a
// narrow ACC_W=4 one whose block sums can exceed the result width.
module tb_fir_decimator;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_en = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       out_valid_a, out_valid_b;
  logic [5:0] out_data_a;
  logic [3:0] out_data_b;
  logic [2:0] fifo_count_a, fifo_count_b;
  logic       overflow_a, overflow_b;

  fir_decimator #(.IN_W(4), .DECIM(DECIM), .ACC_W(6), .DEPTH(DEPTH)) u_dut_a (
    .clock(clock), .reset(reset), .in_en(in_en), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .fifo_count(fifo_count_a), .overflow(overflow_a), .clr_ovf(clr_ovf));

  fir_decimator #(.IN_W(4), .DECIM(DECIM), .ACC_W(4), .DEPTH(DEPTH)) u_dut_b (
    .clock(clock), .reset(reset), .in_en(in_en), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .fifo_count(fifo_count_b), .overflow(overflow_b), .clr_ovf(clr_ovf));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: samples in the current block, queued results per width.
  int blk_n = 0;
  int blk_sum = 0;
  int q_a[$];
  int q_b[$];
  bit ovf = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result of a block whose true sum is s, reduced to a w-bit result.
  function automatic int blk_res(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef FIR_DEC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  function automatic int head(input int q[$]);
    return (q.size() != 0) ? q[0] : 0;
  endfunction

  task automatic model_clear();
    blk_n = 0; blk_sum = 0; q_a.delete(); q_b.delete(); ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_a"}, int'(out_valid_a), int'(q_a.size() != 0));
    chk({tag, ".data_a"},  int'(out_data_a),  head(q_a));
    chk({tag, ".count_a"}, int'(fifo_count_a), q_a.size());
    chk({tag, ".ovf_a"},   int'(overflow_a),  int'(ovf));
    chk({tag, ".valid_b"}, int'(out_valid_b), int'(q_b.size() != 0));
    chk({tag, ".data_b"},  int'(out_data_b),  head(q_b));
    chk({tag, ".count_b"}, int'(fifo_count_b), q_b.size());
    chk({tag, ".ovf_b"},   int'(overflow_b),  int'(ovf));
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input string tag, input bit en, input int d,
                      input bit rdy, input bit clr);
    bit pop, done;
    int occ;
    in_en = en; in_data = 4'(d); out_ready = rdy; clr_ovf = clr;
    occ  = q_a.size();
    pop  = (occ != 0) && rdy;
    done = 1'b0;
    if (en) begin
      blk_sum += d; blk_n++;
      done = (blk_n == DECIM);
    end
    if (pop) begin void'(q_a.pop_front()); void'(q_b.pop_front()); end
    if (done) begin
      if (occ < DEPTH || pop) begin
        q_a.push_back(blk_res(blk_sum, 6));
        q_b.push_back(blk_res(blk_sum, 4));
      end else begin
        ovf = 1'b1;
      end
      blk_n = 0; blk_sum = 0;
    end else if (clr) begin
      ovf = 1'b0;
    end
    if (done && ovf && (occ >= DEPTH && !pop)) ovf = 1'b1;
    else if (clr && !(done && occ >= DEPTH && !pop)) ovf = 1'b0;
    @(posedge clock); #1;
    check_outputs(tag);
    @(negedge clock);
  endtask

  task automatic block(input string tag, input int a, input int b,
                       input int c, input int d, input bit rdy);
    step(tag, 1, a, rdy, 0); step(tag, 1, b, rdy, 0);
    step(tag, 1, c, rdy, 0); step(tag, 1, d, rdy, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) step(tag, 0, $urandom_range(15), 1, 0);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1 model_clear();
    check_outputs("reset");
    @(negedge clock); reset = 1'b1;

    // Basic block 1,2,3,4 -> 10, then popped
    block("basic", 1, 2, 3, 4, 0);
    chk("basic.sum", int'(out_data_a), 10);
    chk("basic.cnt", int'(fifo_count_a), 1);
    step("basic_pop", 0, 0, 1, 0);
    chk("basic.empty", int'(out_valid_a), 0);

    // Gapped 15s -> single result 60; no early output
    for (int i = 0; i < DECIM; i++) begin
      step("gap", 1, 15, 0, 0);
      if (i != DECIM - 1) begin
        chk("gap.noout", int'(out_valid_a), 0);
        step("gap_idle", 0, $urandom_range(15), 0, 0);
      end
    end
    chk("gap.sum", int'(out_data_a), 60);
    drain("gap_drain");

    // Backpressure: five blocks of 1s into a 4-deep FIFO
    for (int b = 0; b < 5; b++) block("bp", 1, 1, 1, 1, 0);
    chk("bp.cnt", int'(fifo_count_a), 4);
    chk("bp.ovf", int'(overflow_a), 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp.drain", int'(out_data_a), 4);
      step("bp_drain", 0, 0, 1, 0);
    end
    step("bp_clr", 0, 0, 0, 1);
    chk("bp.clr", int'(overflow_a), 0);

    // Full FIFO, completing block coincides with a pop
    for (int b = 0; b < 4; b++) block("full", b + 1, 0, 0, 0, 0);
    step("full5", 1, 5, 0, 0); step("full5", 1, 0, 0, 0);
    step("full5", 1, 0, 0, 0); step("full5", 1, 0, 1, 0);
    chk("full.cnt", int'(fifo_count_a), 4);
    chk("full.ovf", int'(overflow_a), 0);
    chk("full.head", int'(out_data_a), 2);
    drain("full_drain");

    // Set and clear in the same cycle: set wins
    for (int b = 0; b < 4; b++) block("sc", 2, 2, 2, 2, 0);
    step("sc", 1, 3, 0, 0); step("sc", 1, 3, 0, 0); step("sc", 1, 3, 0, 0);
    step("sc_last", 1, 3, 0, 1);
    chk("sc.ovf", int'(overflow_a), 1);
    step("sc_clr", 0, 0, 0, 1);
    drain("sc_drain");

    // Async reset mid-block
    block("pre", 7, 7, 7, 7, 0);
    step("mid", 1, 5, 0, 0); step("mid", 1, 6, 0, 0);
    #2 reset = 1'b0;
    #1 model_clear();
    check_outputs("async_rst");
    @(negedge clock); reset = 1'b1;
    block("post_rst", 1, 1, 1, 1, 0);
    chk("post_rst.sum", int'(out_data_a), 4);
    drain("post_drain");

    // Narrow width: 8,8,8,8 = 32
    block("narrow", 8, 8, 8, 8, 0);
`ifdef FIR_DEC_SAT_EN
    chk("narrow.sat", int'(out_data_b), 15);
`else
    chk("narrow.wrap", int'(out_data_b), 0);
`endif
    chk("narrow.wide", int'(out_data_a), 32);
    drain("narrow_drain");

    // Random traffic with bursts of backpressure
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      rdy = ((i / 40) % 3 == 1) ? 1'b0 : ($urandom_range(3) != 0);
      step("rand", $urandom_range(3) != 0, $urandom_range(15), rdy,
           $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
